// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : id_decode_stage
// Registered, handshaked MIPS instruction decoder with multiplier issue stall.
// Rev    : 1.0
// ============================================================================
module id_decode_stage #(
    parameter int MUL_LATENCY = 4,
    parameter int ALUCTL_W    = 5
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [31:0]         Instruction,
    input  logic                InValid,
    output logic                InReady,
    input  logic                OutReady,
    input  logic                Flush,
    output logic                OutValid,
    output logic                RegDst,
    output logic                ALUSrc,
    output logic                ALUSrc2,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                Branch,
    output logic                Jump,
    output logic                Link,
    output logic [1:0]          Datatype,
    output logic [1:0]          HI_LO_Write,
    output logic [ALUCTL_W-1:0] ALUControl,
    output logic                Illegal
);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MULBUSY = 1'b1
    } t_state;

    typedef struct packed {
        logic                reg_dst;
        logic                alu_src;
        logic                alu_src2;
        logic                mem_to_reg;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                jump;
        logic                link;
        logic [1:0]          datatype;
        logic [1:0]          hi_lo_write;
        logic [ALUCTL_W-1:0] alu_control;
        logic                illegal;
    } t_bundle;

    function automatic t_bundle f_default_bundle();
        t_bundle b;
        b             = '0;
        b.alu_control = ALUCTL_W'(5'd31);
        return b;
    endfunction

    logic [5:0] w_op;
    logic [5:0] w_funct;
    logic [4:0] w_rt;
    logic [4:0] w_shamt;
    assign w_op    = Instruction[31:26];
    assign w_rt    = Instruction[20:16];
    assign w_shamt = Instruction[10:6];
    assign w_funct = Instruction[5:0];

    // rd and the upper rs bits never influence control
    logic w_unused_bits;
    assign w_unused_bits = ^{Instruction[25:22], Instruction[15:11]};

    t_bundle    w_dec;
    logic [4:0] w_alu;
    logic       w_ill;
    logic       w_mul_op;

    always_comb begin
        w_dec    = f_default_bundle();
        w_alu    = 5'd31;
        w_ill    = 1'b0;
        w_mul_op = 1'b0;
        case (w_op)
            6'h00: begin
                w_dec.reg_dst   = 1'b1;
                w_dec.reg_write = 1'b1;
                case (w_funct)
                    6'h00: begin w_alu = 5'd7;  w_dec.alu_src2 = 1'b1; end
                    6'h02: begin w_alu = Instruction[21] ? 5'd9 : 5'd8; w_dec.alu_src2 = 1'b1; end
                    6'h03: begin w_alu = 5'd13; w_dec.alu_src2 = 1'b1; end
                    6'h04: w_alu = 5'd7;
                    6'h06: w_alu = Instruction[6] ? 5'd9 : 5'd8;
                    6'h07: w_alu = 5'd13;
                    6'h08: begin w_alu = 5'd0; w_dec.jump = 1'b1; w_dec.reg_write = 1'b0; end
                    6'h0A: w_alu = 5'd12;
                    6'h0B: w_alu = 5'd11;
                    6'h10: w_alu = 5'd17;
                    6'h11: begin w_alu = 5'd15; w_dec.reg_write = 1'b0; w_dec.hi_lo_write = 2'd1; end
                    6'h12: w_alu = 5'd18;
                    6'h13: begin w_alu = 5'd16; w_dec.reg_write = 1'b0; w_dec.hi_lo_write = 2'd2; end
                    6'h18, 6'h19: begin
                        w_alu = 5'd2; w_dec.reg_write = 1'b0; w_dec.hi_lo_write = 2'd3; w_mul_op = 1'b1;
                    end
                    6'h20, 6'h21: w_alu = 5'd0;
                    6'h22, 6'h23: w_alu = 5'd1;
                    6'h24: w_alu = 5'd3;
                    6'h25: w_alu = 5'd4;
                    6'h26: w_alu = 5'd6;
                    6'h27: w_alu = 5'd5;
                    6'h2A: w_alu = 5'd10;
                    6'h2B: w_alu = 5'd14;
                    default: w_ill = 1'b1;
                endcase
            end
            6'h1C: begin
                case (w_funct)
                    6'h00: begin w_alu = 5'd20; w_dec.hi_lo_write = 2'd3; w_mul_op = 1'b1; end
                    6'h04: begin w_alu = 5'd21; w_dec.hi_lo_write = 2'd3; w_mul_op = 1'b1; end
                    6'h02: begin w_alu = 5'd19; w_dec.reg_dst = 1'b1; w_dec.reg_write = 1'b1; end
                    default: w_ill = 1'b1;
                endcase
            end
            6'h23, 6'h21, 6'h20: begin
                w_alu            = 5'd0;
                w_dec.alu_src    = 1'b1;
                w_dec.mem_to_reg = 1'b1;
                w_dec.reg_write  = 1'b1;
                w_dec.mem_read   = 1'b1;
                w_dec.datatype   = (w_op == 6'h23) ? 2'd0 : (w_op == 6'h21) ? 2'd1 : 2'd2;
            end
            6'h2B, 6'h29, 6'h28: begin
                w_alu           = 5'd0;
                w_dec.alu_src   = 1'b1;
                w_dec.mem_write = 1'b1;
                w_dec.datatype  = (w_op == 6'h2B) ? 2'd0 : (w_op == 6'h29) ? 2'd1 : 2'd2;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_dec.alu_src   = 1'b1;
                w_dec.reg_write = 1'b1;
                case (w_op[2:0])
                    3'd2:    w_alu = 5'd10;
                    3'd3:    w_alu = 5'd14;
                    3'd4:    w_alu = 5'd3;
                    3'd5:    w_alu = 5'd4;
                    3'd6:    w_alu = 5'd6;
                    3'd7:    w_alu = 5'd26;
                    default: w_alu = 5'd0;
                endcase
            end
            6'h04: begin w_alu = 5'd29; w_dec.branch = 1'b1; end
            6'h05: begin w_alu = 5'd30; w_dec.branch = 1'b1; end
            6'h06: begin w_alu = 5'd28; w_dec.branch = 1'b1; end
            6'h07: begin w_alu = 5'd27; w_dec.branch = 1'b1; end
            6'h01: begin
                w_dec.branch = 1'b1;
                if (w_rt == 5'd1)      w_alu = 5'd24;
                else if (w_rt == 5'd0) w_alu = 5'd25;
                else                   w_ill = 1'b1;
            end
            6'h02: w_dec.jump = 1'b1;
            6'h03: begin w_dec.jump = 1'b1; w_dec.link = 1'b1; w_dec.reg_write = 1'b1; end
            6'h1F: begin
                w_dec.reg_dst   = 1'b1;
                w_dec.reg_write = 1'b1;
                if (w_shamt == 5'h18)      w_alu = 5'd22;
                else if (w_shamt == 5'h10) w_alu = 5'd23;
                else                       w_ill = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec         = f_default_bundle();
            w_dec.illegal = 1'b1;
            w_mul_op      = 1'b0;
        end else begin
            w_dec.alu_control = ALUCTL_W'(w_alu);
        end
    end

    t_state  r_state;
    t_state  w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic    r_out_valid;
    t_bundle r_bundle;
    logic    w_busy;
    logic    w_accept;

    assign w_busy   = (r_state == S_MULBUSY);
    assign InReady  = !w_busy && (!r_out_valid || OutReady);
    assign w_accept = InValid && InReady;

    // Leaving MULBUSY on the cnt==1 edge blocks exactly MUL_LATENCY-1 cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_mul_op && (MUL_LATENCY > 1)) begin
                    w_state_nxt = S_MULBUSY;
                    w_cnt_nxt   = 4'(MUL_LATENCY - 1);
                end
            end
            S_MULBUSY: begin
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_bundle    <= f_default_bundle();
        end else if (Flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_bundle    <= w_dec;
            end else if (OutReady) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign OutValid    = r_out_valid;
    assign RegDst      = r_bundle.reg_dst;
    assign ALUSrc      = r_bundle.alu_src;
    assign ALUSrc2     = r_bundle.alu_src2;
    assign MemtoReg    = r_bundle.mem_to_reg;
    assign RegWrite    = r_bundle.reg_write;
    assign MemRead     = r_bundle.mem_read;
    assign MemWrite    = r_bundle.mem_write;
    assign Branch      = r_bundle.branch;
    assign Jump        = r_bundle.jump;
    assign Link        = r_bundle.link;
    assign Datatype    = r_bundle.datatype;
    assign HI_LO_Write = r_bundle.hi_lo_write;
    assign ALUControl  = r_bundle.alu_control;
    assign Illegal     = r_bundle.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_decode_stage
// Randomised and directed bench for id_decode_stage against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_id_decode_stage;

    localparam int MUL_LATENCY = 4;
    localparam int ALUCTL_W    = 5;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instruction = '0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b1;
    logic        Flush = 1'b0;
    logic        InReady, OutValid;
    logic        RegDst, ALUSrc, ALUSrc2, MemtoReg, RegWrite, MemRead, MemWrite;
    logic        Branch, Jump, Link, Illegal;
    logic [1:0]  Datatype, HI_LO_Write;
    logic [ALUCTL_W-1:0] ALUControl;

    id_decode_stage #(.MUL_LATENCY(MUL_LATENCY), .ALUCTL_W(ALUCTL_W)) dut (
        .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InValid(InValid),
        .InReady(InReady), .OutReady(OutReady), .Flush(Flush), .OutValid(OutValid),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUSrc2(ALUSrc2), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .Jump(Jump), .Link(Link), .Datatype(Datatype), .HI_LO_Write(HI_LO_Write),
        .ALUControl(ALUControl), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       ill;
        logic [4:0] alu;
        logic [1:0] hl;
        logic [1:0] dt;
        logic lk, j, br, mw, mr, rw, m2r, as2, as_, rd;
    } exp_t;

    localparam logic [9:0] F_RD = 10'd1,  F_AS = 10'd2,  F_AS2 = 10'd4, F_M2R = 10'd8;
    localparam logic [9:0] F_RW = 10'd16, F_MR = 10'd32, F_MW = 10'd64, F_BR = 10'd128;
    localparam logic [9:0] F_J  = 10'd256, F_LK = 10'd512;

    int total = 0;
    int bad   = 0;

    function automatic exp_t mk(int alu, logic [9:0] f, int dt, int hl);
        exp_t e;
        e     = '0;
        e.alu = alu[4:0];
        e.dt  = dt[1:0];
        e.hl  = hl[1:0];
        {e.lk, e.j, e.br, e.mw, e.mr, e.rw, e.m2r, e.as2, e.as_, e.rd} = f;
        return e;
    endfunction

    function automatic exp_t default_b();
        return mk(31, 10'd0, 0, 0);
    endfunction

    function automatic exp_t ill_b();
        exp_t e;
        e     = default_b();
        e.ill = 1'b1;
        return e;
    endfunction

    // Mnemonic-level reference decode
    function automatic exp_t ref_decode(logic [31:0] i);
        logic [5:0] op, fn;
        logic [4:0] rt, sh;
        op = i[31:26]; fn = i[5:0]; rt = i[20:16]; sh = i[10:6];
        case (op)
            6'h00: case (fn)
                6'h00: return mk(7, F_RD | F_RW | F_AS2, 0, 0);
                6'h02: return mk(i[21] ? 9 : 8, F_RD | F_RW | F_AS2, 0, 0);
                6'h03: return mk(13, F_RD | F_RW | F_AS2, 0, 0);
                6'h04: return mk(7, F_RD | F_RW, 0, 0);
                6'h06: return mk(i[6] ? 9 : 8, F_RD | F_RW, 0, 0);
                6'h07: return mk(13, F_RD | F_RW, 0, 0);
                6'h08: return mk(0, F_RD | F_J, 0, 0);
                6'h0A: return mk(12, F_RD | F_RW, 0, 0);
                6'h0B: return mk(11, F_RD | F_RW, 0, 0);
                6'h10: return mk(17, F_RD | F_RW, 0, 0);
                6'h11: return mk(15, F_RD, 0, 1);
                6'h12: return mk(18, F_RD | F_RW, 0, 0);
                6'h13: return mk(16, F_RD, 0, 2);
                6'h18, 6'h19: return mk(2, F_RD, 0, 3);
                6'h20, 6'h21: return mk(0, F_RD | F_RW, 0, 0);
                6'h22, 6'h23: return mk(1, F_RD | F_RW, 0, 0);
                6'h24: return mk(3, F_RD | F_RW, 0, 0);
                6'h25: return mk(4, F_RD | F_RW, 0, 0);
                6'h26: return mk(6, F_RD | F_RW, 0, 0);
                6'h27: return mk(5, F_RD | F_RW, 0, 0);
                6'h2A: return mk(10, F_RD | F_RW, 0, 0);
                6'h2B: return mk(14, F_RD | F_RW, 0, 0);
                default: return ill_b();
            endcase
            6'h1C: case (fn)
                6'h00: return mk(20, 10'd0, 0, 3);
                6'h04: return mk(21, 10'd0, 0, 3);
                6'h02: return mk(19, F_RD | F_RW, 0, 0);
                default: return ill_b();
            endcase
            6'h23: return mk(0, F_AS | F_M2R | F_RW | F_MR, 0, 0);
            6'h21: return mk(0, F_AS | F_M2R | F_RW | F_MR, 1, 0);
            6'h20: return mk(0, F_AS | F_M2R | F_RW | F_MR, 2, 0);
            6'h2B: return mk(0, F_AS | F_MW, 0, 0);
            6'h29: return mk(0, F_AS | F_MW, 1, 0);
            6'h28: return mk(0, F_AS | F_MW, 2, 0);
            6'h08, 6'h09: return mk(0, F_AS | F_RW, 0, 0);
            6'h0C: return mk(3, F_AS | F_RW, 0, 0);
            6'h0D: return mk(4, F_AS | F_RW, 0, 0);
            6'h0E: return mk(6, F_AS | F_RW, 0, 0);
            6'h0A: return mk(10, F_AS | F_RW, 0, 0);
            6'h0B: return mk(14, F_AS | F_RW, 0, 0);
            6'h0F: return mk(26, F_AS | F_RW, 0, 0);
            6'h04: return mk(29, F_BR, 0, 0);
            6'h05: return mk(30, F_BR, 0, 0);
            6'h07: return mk(27, F_BR, 0, 0);
            6'h06: return mk(28, F_BR, 0, 0);
            6'h01: return (rt == 5'd1) ? mk(24, F_BR, 0, 0) :
                          (rt == 5'd0) ? mk(25, F_BR, 0, 0) : ill_b();
            6'h02: return mk(31, F_J, 0, 0);
            6'h03: return mk(31, F_J | F_LK | F_RW, 0, 0);
            6'h1F: return (sh == 5'h18) ? mk(22, F_RD | F_RW, 0, 0) :
                          (sh == 5'h10) ? mk(23, F_RD | F_RW, 0, 0) : ill_b();
            default: return ill_b();
        endcase
    endfunction

    function automatic bit is_mul(logic [31:0] i);
        return (i[31:26] == 6'h00 && (i[5:0] == 6'h18 || i[5:0] == 6'h19)) ||
               (i[31:26] == 6'h1C && (i[5:0] == 6'h00 || i[5:0] == 6'h04));
    endfunction

    logic [5:0] legal_ops [27] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
        6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h1C, 6'h1C,
        6'h1F, 6'h20, 6'h21, 6'h23, 6'h28, 6'h29, 6'h2B};
    logic [5:0] r_functs [25] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h0A,
        6'h0B, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
        6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            r[31:26] = legal_ops[$urandom_range(0, 26)];
            case (r[31:26])
                6'h00: if ($urandom_range(0, 7) != 0) r[5:0] = r_functs[$urandom_range(0, 24)];
                6'h1C: case ($urandom_range(0, 3))
                    0: r[5:0] = 6'h00;
                    1: r[5:0] = 6'h02;
                    2: r[5:0] = 6'h04;
                    default: ;
                endcase
                6'h01: if ($urandom_range(0, 3) != 0) r[20:16] = 5'($urandom_range(0, 1));
                6'h1F: case ($urandom_range(0, 2))
                    0: r[10:6] = 5'h18;
                    1: r[10:6] = 5'h10;
                    default: ;
                endcase
                default: ;
            endcase
        end
        return r;
    endfunction

    // Behavioural model state
    bit   m_known = 0;
    bit   m_valid = 0;
    bit   m_after_reset = 0;
    int   m_busy = 0;
    exp_t m_bund;
    logic s_inready;

    function automatic exp_t dut_b();
        return {Illegal, ALUControl, HI_LO_Write, Datatype, Link, Jump, Branch,
                MemWrite, MemRead, RegWrite, MemtoReg, ALUSrc2, ALUSrc, RegDst};
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic rst, input logic fl, input logic iv, input logic ordy,
                         input logic [31:0] ins);
        bit m_ready;
        Reset = rst; Flush = fl; InValid = iv; OutReady = ordy; Instruction = ins;
        #1;
        s_inready = InReady;
        m_ready = (m_busy == 0) && (!m_valid || ordy);
        if (m_known && !rst) begin
            cmp("outvalid", 32'(OutValid), 32'(m_valid));
            cmp("inready", 32'(InReady), 32'(m_ready));
            if (m_valid || m_after_reset) cmp("bundle", 32'(dut_b()), 32'(m_bund));
        end
        if (rst) begin
            m_known = 1; m_valid = 0; m_busy = 0; m_bund = default_b(); m_after_reset = 1;
        end else if (m_known) begin
            if (fl) begin
                m_valid = 0; m_busy = 0;
            end else if (iv && m_ready) begin
                m_valid = 1; m_after_reset = 0; m_bund = ref_decode(ins);
                m_busy = is_mul(ins) ? MUL_LATENCY - 1 : 0;
            end else begin
                if (ordy) m_valid = 0;
                if (m_busy > 0) m_busy--;
            end
        end
        @(negedge Clk);
    endtask

    localparam logic [31:0] I_ADD = 32'h014B4820;

    initial begin
        @(negedge Clk);
        cycle(1, 0, 0, 1, 0);
        cycle(1, 0, 0, 1, 0);
        cmp("rst.outvalid", 32'(OutValid), 0);
        cmp("rst.alu", 32'(ALUControl), 31);
        cmp("rst.regwrite", 32'(RegWrite), 0);

        cycle(0, 0, 1, 1, I_ADD);
        cmp("add.inready", 32'(s_inready), 1);
        cmp("add.outvalid", 32'(OutValid), 1);
        cmp("add.regdst", 32'(RegDst), 1);
        cmp("add.regwrite", 32'(RegWrite), 1);
        cmp("add.alu", 32'(ALUControl), 0);
        cmp("add.illegal", 32'(Illegal), 0);

        cycle(0, 0, 1, 1, 32'h85090004);
        cmp("lh.memread", 32'(MemRead), 1);
        cmp("lh.memtoreg", 32'(MemtoReg), 1);
        cmp("lh.datatype", 32'(Datatype), 1);
        cycle(0, 0, 1, 1, 32'hA1090003);
        cmp("sb.memwrite", 32'(MemWrite), 1);
        cmp("sb.regwrite", 32'(RegWrite), 0);
        cmp("sb.datatype", 32'(Datatype), 2);

        cycle(0, 0, 1, 1, 32'h71090000);
        cmp("madd.hilo", 32'(HI_LO_Write), 3);
        cmp("madd.alu", 32'(ALUControl), 20);
        for (int k = 1; k <= 3; k++) begin
            cycle(0, 0, 1, 1, I_ADD);
            cmp("madd.busy_inready", 32'(s_inready), 0);
        end
        cycle(0, 0, 1, 1, I_ADD);
        cmp("madd.next_accept", 32'(s_inready), 1);
        cmp("madd.next_outvalid", 32'(OutValid), 1);

        cycle(0, 0, 1, 1, 32'h00094883);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 0, 1, 0, I_ADD);
            cmp("bp.inready", 32'(s_inready), 0);
            cmp("bp.alu", 32'(ALUControl), 13);
            cmp("bp.alusrc2", 32'(ALUSrc2), 1);
            cmp("bp.outvalid", 32'(OutValid), 1);
        end
        cycle(0, 0, 0, 1, 0);
        cmp("bp.release_inready", 32'(s_inready), 1);
        cmp("bp.drained", 32'(OutValid), 0);

        cycle(0, 0, 1, 1, 32'h01090018);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 1, 0);
        cmp("flush.outvalid", 32'(OutValid), 0);
        cycle(0, 0, 1, 1, 32'h8D090004);
        cmp("flush.inready", 32'(s_inready), 1);
        cmp("flush.lw_memread", 32'(MemRead), 1);

        foreach (legal_ops[k]) begin
            if (k < 3) begin
                logic [31:0] bad_ins;
                bad_ins = (k == 0) ? 32'hFC000000 : (k == 1) ? 32'h04020000 : 32'h7C0000C0;
                cycle(0, 0, 1, 1, bad_ins);
                cmp("ill.illegal", 32'(Illegal), 1);
                cmp("ill.alu", 32'(ALUControl), 31);
                cmp("ill.regwrite", 32'(RegWrite), 0);
                cmp("ill.memwrite", 32'(MemWrite), 0);
            end
        end
        cycle(0, 0, 1, 1, 32'h00294882);
        cmp("rotr.alu", 32'(ALUControl), 9);

        for (int n = 0; n < 4000; n++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0), gen_instr());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
